fx2_regbank: RTL and testbench

FX2_REGBANK -- requirements
Module: fx2_regbank

---
 rtl/fx2_pkg.sv | 16 +
 rtl/fx2_sync_edge.sv | 35 +++
 rtl/fx2_regbank.sv | 142 ++++++++++++++
 tb/tb_fx2_regbank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_pkg.sv
// rtl/fx2_pkg.sv - shared FSM state encoding and default FX2 address map
package fx2_pkg;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_RD_DRIVE = 1'b1;

  // Default register map as seen by the FX2 host firmware
  localparam int ADDR_CONTROL    = 0;
  localparam int ADDR_MODE       = 1;
  localparam int ADDR_AMPLITUDE  = 2;
  localparam int ADDR_OFFSET     = 3;
  localparam int ADDR_CONF_FIRST = 4;
  localparam int ADDR_CONF_LAST  = 9;
  localparam int ADDR_ADC_CH     = 16;

endpackage

// File: rtl/fx2_sync_edge.sv
// rtl/fx2_sync_edge.sv - two-flop synchroniser with rising-edge detect in a third stage
module fx2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1, s2, s3;
  logic [1:0] fill;
  logic armed;

  // An edge only counts once a real low has been sampled after reset, so a
  // pin already high at release (or a pending edge) is never reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[0], 1'b1};
      if (fill[1] && !s2) armed <= 1'b1;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3 & armed;

endmodule

// File: rtl/fx2_regbank.sv
// rtl/fx2_regbank.sv - FX2 multiplexed-bus register bank with RW registers and RO channels
module fx2_regbank
  import fx2_pkg::*;
#(
  parameter int DW       = 16,
  parameter int N_RW     = 16,
  parameter int N_RO     = 4,
  parameter int AW       = 5,
  parameter int AUTO_INC = 1,
  parameter logic [N_RW*DW-1:0] RST_VALS = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  inout  wire  [DW-1:0]      fx2_data,
  input  logic               fx2_as,
  input  logic               fx2_ds,
  input  logic               fx2_nrdwr,
  output logic [N_RW*DW-1:0] rw_regs,
  output logic [N_RW-1:0]    wr_stb,
  input  logic [N_RO*DW-1:0] ro_regs,
  output logic [N_RO-1:0]    rd_stb,
  output logic               bad_addr,
  input  logic               bad_clr
);

  logic          as_rise, ds_rise, ds_q;
  logic [DW-1:0] data_s1, data_s2;
  logic          nrdwr_s1, nrdwr_s2;
  logic [AW-1:0] addr;
  logic [31:0]   addr_ext;
  logic [0:0]    state;
  logic [DW-1:0] rd_data, rd_mux;
  logic          ds_act, wr_act, rd_act, in_rw, in_ro, bad_hit;

  fx2_sync_edge u_as_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (fx2_as),
    .q    (),
    .rise (as_rise)
  );

  fx2_sync_edge u_ds_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (fx2_ds),
    .q    (ds_q),
    .rise (ds_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1  <= '0;
      data_s2  <= '0;
      nrdwr_s1 <= 1'b0;
      nrdwr_s2 <= 1'b0;
    end else begin
      data_s1  <= fx2_data;
      data_s2  <= data_s1;
      nrdwr_s1 <= fx2_nrdwr;
      nrdwr_s2 <= nrdwr_s1;
    end
  end

  // An address strobe in the same cycle as a data strobe swallows the data strobe
  assign ds_act   = ds_rise & ~as_rise;
  assign wr_act   = ds_act & nrdwr_s2;
  assign rd_act   = ds_act & ~nrdwr_s2;
  assign addr_ext = 32'(addr);
  assign in_rw    = addr_ext < 32'(N_RW);
  assign in_ro    = !in_rw && (addr_ext < 32'(N_RW + N_RO));
  assign bad_hit  = ds_act && !in_rw && (nrdwr_s2 || !in_ro);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_RW; i++)
      if (addr_ext == 32'(i)) rd_mux = rw_regs[i*DW +: DW];
    for (int j = 0; j < N_RO; j++)
      if (addr_ext == 32'(N_RW + j)) rd_mux = ro_regs[j*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_regs <= RST_VALS;
      wr_stb  <= '0;
      rd_stb  <= '0;
      rd_data <= '0;
    end else begin
      wr_stb <= '0;
      rd_stb <= '0;
      if (wr_act) begin
        for (int i = 0; i < N_RW; i++) begin
          if (addr_ext == 32'(i)) begin
            rw_regs[i*DW +: DW] <= data_s2;
            wr_stb[i]           <= 1'b1;
          end
        end
      end
      if (rd_act) begin
        rd_data <= rd_mux;
        for (int j = 0; j < N_RO; j++)
          if (addr_ext == 32'(N_RW + j)) rd_stb[j] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (as_rise) begin
      addr <= data_s2[AW-1:0];
    end else if (ds_rise && AUTO_INC != 0) begin
      addr <= addr + AW'(1);
    end
  end

  // A bad access in the same cycle as bad_clr leaves the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_addr <= 1'b0;
    end else if (bad_hit) begin
      bad_addr <= 1'b1;
    end else if (bad_clr) begin
      bad_addr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (rd_act) state <= ST_RD_DRIVE;
        ST_RD_DRIVE: if (!ds_q || nrdwr_s2 || as_rise) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  assign fx2_data = (state == ST_RD_DRIVE) ? rd_data : {DW{1'bz}};

endmodule

// File: tb/tb_fx2_regbank.sv
// tb/tb_fx2_regbank.sv - directed bench for fx2_regbank with a cycle-level host-view model
module tb_fx2_regbank;
  import fx2_pkg::*;

  localparam int DW   = 16;
  localparam int N_RW = 16;
  localparam int N_RO = 4;
  localparam int AW   = 5;
  localparam logic [N_RW*DW-1:0] RV = {{((N_RW-2)*DW){1'b0}}, 16'h6700, 16'h0000};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic fx2_as = 1'b0, fx2_ds = 1'b0, fx2_nrdwr = 1'b0, bad_clr = 1'b0;
  logic tb_oe = 1'b0;
  logic [DW-1:0] tb_d = '0;
  tri0 [DW-1:0] fx2_data;
  logic [N_RW*DW-1:0] rw_regs;
  logic [N_RW-1:0]    wr_stb;
  logic [N_RO*DW-1:0] ro_regs = '0;
  logic [N_RO-1:0]    rd_stb;
  logic               bad_addr;

  assign fx2_data = tb_oe ? tb_d : {DW{1'bz}};

  always #5 clk = ~clk;

  fx2_regbank #(
    .DW(DW), .N_RW(N_RW), .N_RO(N_RO), .AW(AW), .AUTO_INC(1), .RST_VALS(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fx2_data(fx2_data), .fx2_as(fx2_as), .fx2_ds(fx2_ds),
    .fx2_nrdwr(fx2_nrdwr), .rw_regs(rw_regs), .wr_stb(wr_stb), .ro_regs(ro_regs),
    .rd_stb(rd_stb), .bad_addr(bad_addr), .bad_clr(bad_clr)
  );

  // Host-view model: what the map holds and what the pins must show
  logic [DW-1:0]   m_regs [N_RW];
  int              m_addr;
  logic            m_bad;
  logic [N_RW-1:0] m_wr;
  logic [N_RO-1:0] m_rd;
  logic            m_drive;
  logic [DW-1:0]   m_bus;

  int n_cmp = 0, n_mis = 0;
  bit cmp_en = 0;
  int wr4_cnt = 0, wr5_cnt = 0, rd0_cnt = 0;
  logic [DW-1:0] got;

  task automatic cmp(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_RW; i++) m_regs[i] = RV[i*DW +: DW];
    m_addr = 0; m_bad = 0; m_wr = '0; m_rd = '0; m_drive = 0; m_bus = '0;
  endfunction

  function automatic void m_ds(input bit wr, input logic [DW-1:0] val, input bit clr);
    bit bad_acc = 0;
    if (wr) begin
      if (m_addr < N_RW) begin m_regs[m_addr] = val; m_wr[m_addr] = 1'b1; end
      else bad_acc = 1;
    end else begin
      m_drive = 1;
      if (m_addr < N_RW) m_bus = m_regs[m_addr];
      else if (m_addr < N_RW + N_RO) begin
        m_bus = ro_regs[(m_addr-N_RW)*DW +: DW];
        m_rd[m_addr-N_RW] = 1'b1;
      end else begin
        m_bus = '0; bad_acc = 1;
      end
    end
    if (bad_acc) m_bad = 1;
    else if (clr) m_bad = 0;
    m_addr = (m_addr + 1) % (1 << AW);
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N_RW*DW-1:0] e;
      for (int i = 0; i < N_RW; i++) e[i*DW +: DW] = m_regs[i];
      cmp("rw_regs", 512'(rw_regs), 512'(e));
      cmp("wr_stb", 512'(wr_stb), 512'(m_wr));
      cmp("rd_stb", 512'(rd_stb), 512'(m_rd));
      cmp("bad_addr", 512'(bad_addr), 512'(m_bad));
      if (!tb_oe) cmp("bus", 512'(fx2_data), 512'(m_drive ? m_bus : '0));
      if (wr_stb[4]) wr4_cnt++;
      if (wr_stb[5]) wr5_cnt++;
      if (rd_stb[0]) rd0_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_as(input logic [DW-1:0] v);
    @(negedge clk); tb_oe = 1; tb_d = v; fx2_nrdwr = 1; fx2_as = 1;
    ticks(3); m_addr = int'(v[AW-1:0]);
    tick();
    @(negedge clk); fx2_as = 0;
    ticks(3);
  endtask

  task automatic do_write(input logic [DW-1:0] v, input bit clr);
    @(negedge clk); tb_oe = 1; tb_d = v; fx2_nrdwr = 1; fx2_ds = 1;
    ticks(2);
    if (clr) begin @(negedge clk); bad_clr = 1; end
    tick(); bad_clr = 0;
    m_ds(1, v, clr);
    tick(); m_wr = '0;
    @(negedge clk); fx2_ds = 0;
    ticks(3);
  endtask

  task automatic do_read(output logic [DW-1:0] val);
    @(negedge clk); tb_oe = 0; fx2_nrdwr = 0; fx2_ds = 1;
    ticks(3); m_ds(0, '0, 0);
    tick(); m_rd = '0; val = fx2_data;
    ticks(2);
    @(negedge clk); fx2_ds = 0;
    ticks(3); m_drive = 0;
  endtask

  task automatic do_collide(input logic [DW-1:0] v);
    @(negedge clk); tb_oe = 1; tb_d = v; fx2_nrdwr = 1; fx2_as = 1; fx2_ds = 1;
    ticks(3); m_addr = int'(v[AW-1:0]);
    tick();
    @(negedge clk); fx2_as = 0; fx2_ds = 0;
    ticks(3);
  endtask

  task automatic do_clr();
    @(negedge clk); bad_clr = 1;
    tick(); bad_clr = 0; m_bad = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    model_reset();
    cmp_en = 1;
    #1;
    cmp("reset_reg1", 512'(rw_regs[31:16]), 512'(16'h6700));
    cmp("reset_bad", 512'(bad_addr), 512'(1'b0));
    cmp("reset_bus", 512'(fx2_data), 512'(16'h0000));
    ticks(3);
    @(negedge clk); rst_n = 1;
    ticks(3);

    // Write two config registers with auto-increment, then read them back
    do_as(16'(ADDR_CONF_FIRST));
    do_write(16'h1234, 0);
    do_write(16'h5678, 0);
    cmp("reg4", 512'(rw_regs[4*DW +: DW]), 512'(16'h1234));
    cmp("reg5", 512'(rw_regs[5*DW +: DW]), 512'(16'h5678));
    cmp("wr4_pulses", 512'(wr4_cnt), 512'(1));
    cmp("wr5_pulses", 512'(wr5_cnt), 512'(1));
    do_as(16'h0004);
    do_read(got); cmp("read_reg4", 512'(got), 512'(16'h1234));
    do_read(got); cmp("read_reg5", 512'(got), 512'(16'h5678));

    // Read-only channels
    ro_regs = {16'h4444, 16'h3333, 16'h2222, 16'hBEEF};
    do_as(16'(ADDR_ADC_CH));
    do_read(got); cmp("read_ro0", 512'(got), 512'(16'hBEEF));
    cmp("rd0_pulses", 512'(rd0_cnt), 512'(1));
    cmp("ro_released", 512'(fx2_data), 512'(16'h0000));
    do_read(got); cmp("read_ro1", 512'(got), 512'(16'h2222));

    // Out-of-map accesses and sticky flag
    do_as(16'h0018);
    do_write(16'hFFFF, 0);
    cmp("bad_after_write", 512'(bad_addr), 512'(1'b1));
    do_as(16'h0018);
    do_read(got); cmp("read_bad", 512'(got), 512'(16'h0000));
    do_clr();
    cmp("bad_cleared", 512'(bad_addr), 512'(1'b0));
    do_as(16'h0018);
    do_write(16'h1111, 1);
    cmp("bad_set_wins", 512'(bad_addr), 512'(1'b1));
    do_as(16'h0002);
    do_write(16'h2222, 1);
    cmp("bad_clr_good", 512'(bad_addr), 512'(1'b0));

    // AS and DS on the same cycle: address loads, nothing written
    do_collide(16'h0007);
    cmp("collide_reg7", 512'(rw_regs[7*DW +: DW]), 512'(16'h0000));
    do_write(16'hA5A5, 0);
    cmp("after_collide_reg7", 512'(rw_regs[7*DW +: DW]), 512'(16'hA5A5));

    // Address wraps from 31 to 0
    do_as(16'h001F);
    do_write(16'hDEAD, 0);
    do_write(16'hCAFE, 0);
    cmp("wrap_reg0", 512'(rw_regs[DW-1:0]), 512'(16'hCAFE));

    // Reset in the middle of a bus read, with DS held high across release
    do_as(16'h0004);
    @(negedge clk); tb_oe = 0; fx2_nrdwr = 0; fx2_ds = 1;
    ticks(3); m_ds(0, '0, 0);
    tick(); m_rd = '0;
    cmp("pre_reset_bus", 512'(fx2_data), 512'(16'h1234));
    @(negedge clk); #2 rst_n = 0;
    model_reset();
    #1;
    cmp("rst_bus_released", 512'(fx2_data), 512'(16'h0000));
    cmp("rst_regs", 512'(rw_regs), 512'(RV));
    ticks(2);
    @(negedge clk); rst_n = 1;
    ticks(6);
    @(negedge clk); fx2_ds = 0;
    ticks(3);
    cmp("no_stale_stb", 512'(rd_stb), 512'(0));
    do_as(16'(ADDR_MODE));
    do_read(got); cmp("read_rst_reg1", 512'(got), 512'(16'h6700));

    ticks(2);
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
